// File: rtl/inst_mem_responder.sv
// Memory-side responder for the fetch/MMU request protocol: one request at a time, fixed access latency.
// Define MEM_RESP_ADDR_CHECK_EN to add the addr_err output and reject out-of-range/unaligned accesses.
module inst_mem_responder #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        Addr,
  inout  wire  [DATA_WIDTH-1:0]        Data,
  input  logic                         we,
  input  logic                         req_valid,
  output logic                         grant,
  output logic                         data_valid,
  output logic                         busy,
`ifdef MEM_RESP_ADDR_CHECK_EN
  output logic                         addr_err,
`endif
  input  logic                         load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_RESP} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic                  drive_rd;

`ifdef MEM_RESP_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

  logic err_q;
  logic addr_bad;

  assign addr_bad = ({1'b0, Addr} >= MEM_BYTES) || (Addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      err_q <= addr_bad;
    end
  end

  assign wr_en   = (state == ST_GRANT) && we_q && !err_q;
  assign rd_data = err_q ? '0 : mem[idx_q];
`else
  // Bits outside the word index are ignored, giving modulo-MEM_DEPTH*4 wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, Addr[ADDR_WIDTH-1:IDX_W+2], Addr[1:0]};

  assign wr_en   = (state == ST_GRANT) && we_q;
  assign rd_data = mem[idx_q];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; a dropped req_valid during BUSY aborts before the response
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (req_valid) state_n = ST_GRANT;
      ST_GRANT: state_n = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: begin
        if (!req_valid) begin
          state_n = ST_IDLE;
        end else if (cnt == 4'd1) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so nothing reaches them from req_valid
  always_comb begin
    grant      = (state == ST_GRANT);
    data_valid = (state == ST_RESP);
    busy       = (state != ST_IDLE);
`ifdef MEM_RESP_ADDR_CHECK_EN
    addr_err   = (state == ST_RESP) && err_q;
`endif
  end

  // Request capture and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx_q <= '0;
      we_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            idx_q <= Addr[2 +: IDX_W];
            we_q  <= we;
          end
        end
        ST_GRANT: cnt <= 4'(LATENCY - 1);
        ST_BUSY:  cnt <= cnt - 4'd1;
        default:  cnt <= cnt;
      endcase
    end
  end

  // Preload is the later assignment so it wins a same-word collision with a grant write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[idx_q] <= Data;
      end
      if (load_en) begin
        mem[load_addr] <= load_data;
      end
    end
  end

  assign drive_rd = (state == ST_RESP) && !we_q;
  assign Data     = drive_rd ? rd_data : 'z;

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the fetch/MMU request protocol: Addr, Data (inout), we, req_valid, grant, data_valid.
- Grants one request at a time and models a word-organised memory with a fixed access latency.
- On reads, drives Data together with a one-cycle data_valid pulse. On writes, captures Data.
- Sits behind the arbiter, opposite the Fetch unit. Also serves as the bench memory model for the core.

Parameters:
- MEM_DEPTH, 16: number of 32-bit words.
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 32: byte address width.
- LATENCY, 2: cycles from grant to data_valid; legal range is 1 to 15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  ADDR_WIDTH  byte address from requester.
- Data  inout  DATA_WIDTH  bidirectional data bus.
- we  input  1  1 = write request, 0 = read request.
- req_valid  input  1  request pending; held high by requester until served.
- grant  output  1  request accepted; one-cycle pulse.
- data_valid  output  1  read data valid, or write acknowledge; one-cycle pulse.
- busy  output  1  high in any state other than IDLE.
- load_en  input  1  bench/boot preload strobe.
- load_addr  input  $clog2(MEM_DEPTH)  word index for preload.
- load_data  input  DATA_WIDTH  preload word.

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high.
  - On reset: state=IDLE, grant=0, data_valid=0, busy=0, Data released to high-Z, latency counter=0, all memory words=0.
  - Reset asserted mid-operation aborts immediately. No data_valid is produced, and a pending write that was not yet committed is dropped.
- Word index is Addr[2 +: $clog2(MEM_DEPTH)]. Addresses wrap modulo MEM_DEPTH*4. Addr[1:0] is ignored.
- FSM states: IDLE, GRANT, BUSY, RESP.
  - IDLE: if req_valid=1, latch Addr index and we. At the next edge go to GRANT with grant=1.
  - GRANT: lasts exactly one cycle.
    - If we=1, the responder samples Data at the end of this cycle and writes the memory word at that edge.
    - Load counter=LATENCY-1.
    - If LATENCY=1, go to RESP; otherwise go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter reaches 1, go to RESP.
    - If req_valid=0 during BUSY, abort: go to IDLE with no data_valid. A committed write is not undone.
  - RESP: data_valid=1 for one cycle.
    - For reads, Data is driven with mem[latched index].
    - Then return to IDLE.
- Timing: with grant high in cycle N, data_valid is high in cycle N+LATENCY.
- Throughput: at least one IDLE cycle separates consecutive grants.
  - A req_valid still high in that IDLE cycle is treated as a new request.
  - Minimum turnaround is therefore LATENCY+2 cycles per access.
- Data bus ownership: the responder drives Data only in RESP with latched we=0. In every other cycle Data is high-Z.
- Read-after-write to the same word returns the new value.
- Preload: when load_en=1, mem[load_addr] is written with load_data at that edge, independent of FSM state.
  - If a preload and a GRANT write target the same word in the same cycle, the preload wins.
  - If a preload targets the word currently being read, the RESP data reflects memory contents at the RESP cycle.
- grant and data_valid are registered outputs; there is no combinational path from req_valid.

Optional Feature:
- Macro: MEM_RESP_ADDR_CHECK_EN.
- When defined:
  - Adds output addr_err (1 bit, reset 0), valid together with data_valid.
  - Requests with Addr >= MEM_DEPTH*4 or Addr[1:0] != 0 are still granted and complete with normal latency.
  - For such requests, addr_err=1 in the RESP cycle, reads return all zeros, and writes are discarded.
- When undefined: no addr_err port, and address wrap/ignore rules apply as above.

Test Plan:
- Preload mem[3]=0xDEADBEEF; read request at Addr=0x0C with LATENCY=2 -> grant at cycle N, data_valid and Data=0xDEADBEEF at N+2, Data high-Z at N+3.
- Write 0x12345678 to Addr=0x08 (Data driven during grant), then read Addr=0x08 -> data_valid with Data=0x12345678. The write itself produces a data_valid acknowledge with Data not driven.
- Hold req_valid high continuously with reads to 0x00, 0x04, 0x08 -> grants spaced exactly LATENCY+2 cycles apart, returning the correct words in order.
- Drop req_valid one cycle after grant (flush) -> no data_valid, FSM back in IDLE, next request served normally.
- Assert reset while in BUSY -> grant=0, data_valid=0, busy=0, Data high-Z immediately; memory cleared to 0.
- With MEM_RESP_ADDR_CHECK_EN, read Addr=0x40 (MEM_DEPTH=16) -> data_valid=1, addr_err=1, Data=0. Without the macro, the same read returns mem[0].
